decoder3to8_stream: RTL

DECODER3TO8_STREAM -- requirements
Module: decoder3to8_stream

---
 rtl/decoder3to8_stream.sv | 72 +++++++
 1 files changed

// File: rtl/decoder3to8_stream.sv
// 3-to-8 one-hot decoder behind a 2-entry valid/ready FIFO, with sticky
// delivered-word map, saturating accepted-beat counter and stall flag.
module decoder3to8_stream #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    output logic [7:0]       out_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr,
    output logic [7:0]       hit_map,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             stall_seen
);

    logic [7:0] mem [2];
    logic       wptr, rptr;
    logic [1:0] occ;
    logic       acc, pop, stall, sat;
    logic [7:0] word, head;

    // Handshake outputs come only from registered occupancy (and reset).
    assign in_ready   = rst_n && (occ != 2'd2);
    assign out_valid  = rst_n && (occ != 2'd0);
    assign head       = mem[rptr];
    assign out_onehot = out_valid ? head : 8'h00;

    assign acc   = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    assign stall = in_valid && !in_ready;
    assign sat   = (beat_cnt == {CNT_W{1'b1}});
    assign word  = en ? (8'h01 << in_code) : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ        <= 2'd0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            hit_map    <= 8'h00;
            beat_cnt   <= '0;
            stall_seen <= 1'b0;
        end else begin
            if (acc) begin
                mem[wptr] <= word;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            case ({acc, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase

            // clr drops history but keeps this cycle's own event.
            if (clr) begin
                hit_map    <= pop ? head : 8'h00;
                beat_cnt   <= acc ? CNT_W'(1) : '0;
                stall_seen <= stall;
            end else begin
                if (pop)        hit_map  <= hit_map | head;
                if (acc && !sat) beat_cnt <= beat_cnt + CNT_W'(1);
                if (stall)      stall_seen <= 1'b1;
            end
        end
    end

endmodule
